// File: rtl/glyph_fetch.sv
// glyph_fetch: reader side of the font character ROM.
//   Accepts character codes over valid/ready, walks the glyph columns by
//   driving the registered ROM address {code, col}, absorbs the 1-cycle ROM
//   read latency and streams the column bytes out over valid/ready with full
//   backpressure. Inversion and last-column flags travel with each byte.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   char_code/char_inv/char_valid character in (sampled on handshake)
//   char_ready                    character can be accepted this cycle
//   rom_addr / rom_data           font ROM address out, read data in
//   byte_data/byte_valid/byte_last/byte_ready  glyph byte stream out
//   busy                          glyph issuing, read in flight or bytes buffered
module glyph_fetch #(
    parameter int unsigned GLYPH_BYTES = 8,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned BUF_DEPTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [ADDR_W-$clog2(GLYPH_BYTES)-1:0]   char_code,
    input  logic                                    char_inv,
    input  logic                                    char_valid,
    output logic                                    char_ready,
    output logic [ADDR_W-1:0]                       rom_addr,
    input  logic [7:0]                              rom_data,
    output logic [7:0]                              byte_data,
    output logic                                    byte_valid,
    input  logic                                    byte_ready,
    output logic                                    byte_last,
    output logic                                    busy
);

    localparam int unsigned COL_W  = $clog2(GLYPH_BYTES);
    localparam int unsigned CODE_W = ADDR_W - COL_W;
    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1) + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GLYPH_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t              state, state_next;
    logic [CODE_W-1:0]   code_q;
    logic                inv_q;
    logic [COL_W-1:0]    col;

    // Issue-side selection (combinational)
    logic                issue_ok, issue_now;
    logic [CODE_W-1:0]   issue_code;
    logic                issue_inv;
    logic [COL_W-1:0]    issue_col;
    logic                accept;

    // Read-tag pipeline: t0 = address registered, t1 = ROM has sampled it
    logic                t0_v, t0_inv, t0_last;
    logic                t1_v, t1_inv, t1_last;
    logic [CNT_W-1:0]    inflight;

    // Output FIFO, entries hold {last, byte already inverted}
    logic [8:0]          mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push, pop;

    assign inflight = CNT_W'(t0_v) + CNT_W'(t1_v);
    // Reserve buffer space for every read in flight so the FIFO never overflows.
    assign issue_ok = (count + inflight) < CNT_W'(BUF_DEPTH);
    assign accept   = char_valid & char_ready;
    assign push     = t1_v;
    assign pop      = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // In IDLE the first column is issued on the handshake edge itself, which
    // gives the two-clock latency to the first byte.
    always_comb begin
        state_next = state;
        char_ready = 1'b0;
        issue_now  = 1'b0;
        issue_code = code_q;
        issue_inv  = inv_q;
        issue_col  = col;
        case (state)
            IDLE: begin
                char_ready = 1'b1;
                issue_code = char_code;
                issue_inv  = char_inv;
                issue_col  = '0;
                issue_now  = char_valid & issue_ok;
                if (char_valid) state_next = ISSUE;
            end
            ISSUE: begin
                issue_now = issue_ok;
                if (issue_ok && col == COL_LAST) begin
                    char_ready = 1'b1;
                    if (!char_valid) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= '0;
            inv_q    <= 1'b0;
            col      <= '0;
            rom_addr <= '0;
            t0_v     <= 1'b0;
            t0_inv   <= 1'b0;
            t0_last  <= 1'b0;
            t1_v     <= 1'b0;
            t1_inv   <= 1'b0;
            t1_last  <= 1'b0;
        end else begin
            if (issue_now) rom_addr <= {issue_code, issue_col};

            if (accept) begin
                code_q <= char_code;
                inv_q  <= char_inv;
            end

            if (state == IDLE) begin
                if (char_valid) col <= issue_ok ? COL_W'(1) : '0;
            end else if (issue_ok) begin
                col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
            end

            t0_v    <= issue_now;
            t0_inv  <= issue_inv;
            t0_last <= (issue_col == COL_LAST);
            t1_v    <= t0_v;
            t1_inv  <= t0_inv;
            t1_last <= t0_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {t1_last, rom_data ^ {8{t1_inv}}};
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign byte_valid = (count != '0);
    assign byte_data  = byte_valid ? mem[rd_ptr][7:0] : '0;
    assign byte_last  = byte_valid ? mem[rd_ptr][8]   : 1'b0;
    assign busy       = (state != IDLE) | (inflight != '0) | (count != '0);

endmodule

// File: tb/tb_glyph_fetch.sv
// tb_glyph_fetch: self-checking bench for glyph_fetch with a behavioural
// font ROM and a byte-queue reference model of the glyph stream.
module tb_glyph_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_code;
    logic        char_inv;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;

    glyph_fetch #(.GLYPH_BYTES(8), .ADDR_W(11), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .char_code(char_code), .char_inv(char_inv), .char_valid(char_valid),
        .char_ready(char_ready), .rom_addr(rom_addr), .rom_data(rom_data),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Font ROM: 2048 x 8, one-cycle registered read
    logic [7:0] rom [2048];
    initial for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    always @(posedge clk) rom_data <= rom[rom_addr];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every accepted character expands into its glyph bytes
    typedef struct { logic [7:0] data; logic last; } byte_t;
    byte_t exp_q[$];
    int    popped = 0;
    logic  stall_prev = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (char_valid && char_ready)
                for (int c = 0; c < 8; c++) begin
                    byte_t b;
                    b.data = rom[char_code * 8 + c] ^ (char_inv ? 8'hFF : 8'h00);
                    b.last = (c == 7);
                    exp_q.push_back(b);
                end
            if (stall_prev) begin
                check("stall_valid", byte_valid, 1);
                check("stall_data", byte_data, held_data);
                check("stall_last", byte_last, held_last);
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", byte_data, 32'hDEAD);
                end else begin
                    check("byte_data", byte_data, exp_q[0].data);
                    check("byte_last", byte_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            stall_prev = byte_valid & ~byte_ready;
            held_data  = byte_data;
            held_last  = byte_last;
        end
    end

    // Cycle advance; byte_ready optionally driven by an LFSR or $urandom
    logic [7:0] lfsr = 8'hA5;
    bit lfsr_mode = 0, rand_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (lfsr_mode) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            byte_ready = lfsr[0];
        end else if (rand_mode) begin
            byte_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_char(input logic [7:0] code, input logic inv);
        bit done = 0;
        char_code  = code;
        char_inv   = inv;
        char_valid = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            done = char_ready;
            tick();
        end
        if (!done) check("char_accept_timeout", 0, 1);
        char_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 1000 && !done; n++) begin
            if (exp_q.size() == 0 && !busy && !byte_valid) done = 1;
            else tick();
        end
        check("drain", done, 1);
    endtask

    int base;
    int ones;

    initial begin
        rst = 1'b1; char_code = '0; char_inv = 1'b0; char_valid = 1'b0; byte_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_last", byte_last, 0);
        check("rst_byte_data", byte_data, 0);
        check("rst_busy", busy, 0);
        check("rst_char_ready", char_ready, 1);

        // Single glyph: address sequence, latency, last flag, busy drop
        base = popped;
        char_code = 8'h41; char_inv = 1'b0; char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check("t1_rom_addr", rom_addr, (k < 8) ? 11'h208 + k : 11'h20F);
            check("t1_valid", byte_valid, (k >= 2 && k <= 9));
            check("t1_last", byte_last, (k == 9));
            check("t1_busy", busy, (k < 10));
            tick();
        end
        drain();
        check("t1_count", popped - base, 8);

        // Back-to-back glyphs: no bubble in either direction
        base = popped; ones = 0;
        char_code = 8'h41; char_inv = 1'b0; char_valid = 1'b1;
        tick();
        char_code = 8'h42;
        for (int k = 0; k < 20; k++) begin
            if (k <= 6) check("t2_char_ready", char_ready, (k == 6));
            if (k >= 2 && k <= 17) check("t2_no_gap", byte_valid, 1);
            if (byte_valid) ones++;
            tick();
            if (k == 6) char_valid = 1'b0;
        end
        check("t2_valid_clks", ones, 16);
        drain();
        check("t2_count", popped - base, 16);

        // LFSR backpressure
        base = popped;
        lfsr_mode = 1;
        send_char(8'h30, 1'b0);
        drain();
        lfsr_mode = 0; byte_ready = 1'b1;
        check("t3_count", popped - base, 8);

        // Full stall: issue stops with four bytes held
        base = popped;
        byte_ready = 1'b0;
        send_char(8'h55, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        check("t4_rom_addr", rom_addr, 11'(8'h55 * 8 + 3));
        check("t4_valid", byte_valid, 1);
        check("t4_busy", busy, 1);
        check("t4_none_out", popped - base, 0);
        byte_ready = 1'b1;
        drain();
        check("t4_count", popped - base, 8);

        // Inversion travels with each glyph
        base = popped;
        send_char(8'h41, 1'b1);
        send_char(8'h41, 1'b0);
        drain();
        check("t5_count", popped - base, 16);

        // Reset mid-glyph
        base = popped;
        send_char(8'h41, 1'b0);
        for (int n = 0; n < 50 && (popped - base) < 3; n++) tick();
        byte_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        check("t6_valid", byte_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_char_ready", char_ready, 1);
        base = popped;
        send_char(8'h20, 1'b0);
        drain();
        for (int k = 0; k < 5; k++) tick();
        check("t6_count", popped - base, 8);

        // Randomized characters, gaps and backpressure
        base = popped;
        rand_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_char(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                for (int g = 0; g < int'($urandom_range(1, 12)); g++) tick();
        end
        drain();
        rand_mode = 0; byte_ready = 1'b1;
        check("rand_count", popped - base, 320);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
